// File: rtl/wb_proj_mux_pkg.sv
// ----------------------------------------------------------------------------
// wb_proj_mux_pkg
// Shared definitions for the Wishbone project multiplexer:
//   - FSM state encoding (IDLE / BUSY / RESP)
//   - CSR word offsets inside slot 0
//   - STATUS register bit positions
//   - address field positions for region and slot decode
//   - byte_merge(): applies Wishbone byte selects to a register image
// ----------------------------------------------------------------------------
package wb_proj_mux_pkg;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_BUSY = 2'd1;
  localparam fsm_state_t ST_RESP = 2'd2;

  // CSR byte offsets within slot 0 (adr[19:0])
  localparam logic [19:0] CSR_PROJ_EN  = 20'h0_0000;
  localparam logic [19:0] CSR_PROJ_RST = 20'h0_0004;
  localparam logic [19:0] CSR_STATUS   = 20'h0_0008;
  localparam logic [19:0] CSR_ID       = 20'h0_000C;

  // STATUS layout
  localparam int STS_TIMEOUT_BIT  = 0;
  localparam int STS_SLOT_LSB     = 4;
  localparam int STS_SLOT_MSB     = 7;
  localparam int STS_UNMAPPED_BIT = 8;

  // Address fields
  localparam int REGION_MSB = 31;
  localparam int REGION_LSB = 24;
  localparam int SLOT_MSB   = 23;
  localparam int SLOT_LSB   = 20;

  localparam logic [3:0] CSR_SLOT = 4'd0;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  sel);
    logic [31:0] merged;
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = sel[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_proj_mux_csr.sv
// ----------------------------------------------------------------------------
// wb_proj_mux_csr
// Local CSR bank of the project multiplexer (slot 0).
//   0x0 PROJ_EN  RW  per-project enable, reset 0
//   0x4 PROJ_RST RW  per-project soft reset, reset all ones
//   0x8 STATUS   bit0 sticky timeout (W1C), bits[7:4] slot of last timeout,
//                bit8 sticky unmapped access (W1C)
//   0xC ID       RO  ID_WORD
// Writes honour byte selects; undefined offsets read 0.
// Build option: WB_PROJ_MUX_IRQ_EN drives err_irq = STATUS bit0 | bit8,
// otherwise err_irq is tied low.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en             one-cycle write strobe for the addressed CSR
//   off, wdat, sel    CSR offset, write data, byte selects
//   set_timeout       set STATUS bit0 and record timeout_slot
//   set_unmapped      set STATUS bit8
//   proj_en, proj_rst register contents
//   rdata             combinational read data for off
//   err_irq           error interrupt level
// ----------------------------------------------------------------------------
module wb_proj_mux_csr
  import wb_proj_mux_pkg::*;
#(
  parameter int          NUM_PROJ = 4,
  parameter logic [31:0] ID_WORD  = 32'h1C5C_0001
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [19:0]         off,
  input  logic [31:0]         wdat,
  input  logic [3:0]          sel,
  input  logic                set_timeout,
  input  logic [3:0]          timeout_slot,
  input  logic                set_unmapped,
  output logic [NUM_PROJ-1:0] proj_en,
  output logic [NUM_PROJ-1:0] proj_rst,
  output logic [31:0]         rdata,
  output logic                err_irq
);

  logic        sts_timeout;
  logic        sts_unmapped;
  logic [3:0]  sts_slot;
  logic [31:0] en_merged;
  logic [31:0] rst_merged;
  logic [31:0] sts_word;
  logic        unused_bits;

  assign en_merged  = byte_merge(32'(proj_en),  wdat, sel);
  assign rst_merged = byte_merge(32'(proj_rst), wdat, sel);

  // Only the low NUM_PROJ bits of the merged images are storage.
  assign unused_bits = ^{wdat, en_merged, rst_merged};

  always_comb begin
    sts_word = '0;
    sts_word[STS_TIMEOUT_BIT]             = sts_timeout;
    sts_word[STS_SLOT_MSB:STS_SLOT_LSB]   = sts_slot;
    sts_word[STS_UNMAPPED_BIT]            = sts_unmapped;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      proj_en      <= '0;
      proj_rst     <= '1;
      sts_timeout  <= 1'b0;
      sts_unmapped <= 1'b0;
      sts_slot     <= 4'd0;
    end else begin
      if (wr_en && off == CSR_PROJ_EN)  proj_en  <= en_merged[NUM_PROJ-1:0];
      if (wr_en && off == CSR_PROJ_RST) proj_rst <= rst_merged[NUM_PROJ-1:0];
      // Hardware set and software clear never coincide: CSR writes only
      // happen in IDLE, timeouts only in BUSY.
      if (set_timeout) begin
        sts_timeout <= 1'b1;
        sts_slot    <= timeout_slot;
      end else if (wr_en && off == CSR_STATUS && sel[0] && wdat[STS_TIMEOUT_BIT]) begin
        sts_timeout <= 1'b0;
      end
      if (set_unmapped) begin
        sts_unmapped <= 1'b1;
      end else if (wr_en && off == CSR_STATUS && sel[1] && wdat[STS_UNMAPPED_BIT]) begin
        sts_unmapped <= 1'b0;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (off)
      CSR_PROJ_EN:  rdata = 32'(proj_en);
      CSR_PROJ_RST: rdata = 32'(proj_rst);
      CSR_STATUS:   rdata = sts_word;
      CSR_ID:       rdata = ID_WORD;
      default:      rdata = '0;
    endcase
  end

`ifdef WB_PROJ_MUX_IRQ_EN
  assign err_irq = sts_timeout | sts_unmapped;
`else
  assign err_irq = 1'b0;
`endif

endmodule

// File: rtl/wb_proj_mux.sv
// ----------------------------------------------------------------------------
// wb_proj_mux
// Wishbone slave fabric between the SoC bus and NUM_PROJ user projects.
// adr[31:24]==REGION selects this block; adr[23:20] is the slot:
// slot 0 = CSR bank, slot s (1..NUM_PROJ) = project s-1, anything else is
// unmapped and answered with ERR_WORD. A project that does not ack within
// TIMEOUT_CYC cycles is cut off and answered with ERR_WORD.
// Build option: WB_PROJ_MUX_IRQ_EN enables err_irq_o (see CSR bank).
// Ports:
//   wb_clk_i, wb_rst_i            clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i/sel_i    SoC slave controls
//   wbs_adr_i, wbs_dat_i          address, write data
//   wbs_ack_o, wbs_dat_o          single-cycle ack, registered read data
//   prj_cyc_o, prj_stb_o          per-project gated cyc/stb
//   prj_we_o/sel_o/adr_o/dat_o    shared request fields to all projects
//   prj_ack_i, prj_dat_i          per-project ack, flattened read data
//   prj_rst_o                     per-project reset
//   err_irq_o                     error interrupt
// ----------------------------------------------------------------------------
module wb_proj_mux
  import wb_proj_mux_pkg::*;
#(
  parameter int          NUM_PROJ    = 4,
  parameter logic [7:0]  REGION      = 8'h30,
  parameter int          TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_WORD    = 32'hDEAD_BEEF,
  parameter logic [31:0] ID_WORD     = 32'h1C5C_0001
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     wbs_cyc_i,
  input  logic                     wbs_stb_i,
  input  logic                     wbs_we_i,
  input  logic [3:0]               wbs_sel_i,
  input  logic [31:0]              wbs_adr_i,
  input  logic [31:0]              wbs_dat_i,
  output logic                     wbs_ack_o,
  output logic [31:0]              wbs_dat_o,
  output logic [NUM_PROJ-1:0]      prj_cyc_o,
  output logic [NUM_PROJ-1:0]      prj_stb_o,
  output logic                     prj_we_o,
  output logic [3:0]               prj_sel_o,
  output logic [19:0]              prj_adr_o,
  output logic [31:0]              prj_dat_o,
  input  logic [NUM_PROJ-1:0]      prj_ack_i,
  input  logic [32*NUM_PROJ-1:0]   prj_dat_i,
  output logic [NUM_PROJ-1:0]      prj_rst_o,
  output logic                     err_irq_o
);

  localparam logic [3:0]  LAST_SLOT = 4'(NUM_PROJ);
  localparam logic [15:0] TO_LIMIT  = 16'(TIMEOUT_CYC);

  fsm_state_t state;
  logic [15:0] to_cnt;
  logic [15:0] to_next;
  logic        to_hit;

  logic [3:0]  prj_p1;
  logic        we_p1;
  logic [3:0]  sel_p1;
  logic [19:0] adr_p1;
  logic [31:0] dat_p1;

  logic        stb_req;
  logic        region_hit;
  logic [3:0]  slot;
  logic [3:0]  slot_prj;
  logic        csr_hit;
  logic        prj_hit;
  logic        slot_en;
  logic        idle_req;

  logic [NUM_PROJ-1:0] proj_en;
  logic [NUM_PROJ-1:0] proj_rst;
  logic [31:0]         csr_rdata;
  logic                csr_wr;
  logic                set_timeout;
  logic                set_unmapped;

  logic                ack_p;
  logic [31:0]         dat_p;
  logic [NUM_PROJ-1:0] gate;

  // Request decode on the live bus
  assign stb_req    = wbs_cyc_i & wbs_stb_i;
  assign region_hit = (wbs_adr_i[REGION_MSB:REGION_LSB] == REGION);
  assign slot       = wbs_adr_i[SLOT_MSB:SLOT_LSB];
  assign slot_prj   = slot - 4'd1;
  assign csr_hit    = region_hit && (slot == CSR_SLOT);
  assign prj_hit    = region_hit && (slot != CSR_SLOT) && (slot <= LAST_SLOT);
  assign idle_req   = (state == ST_IDLE) && stb_req;

  always_comb begin
    slot_en = 1'b0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      if (slot_prj == 4'(i)) slot_en = proj_en[i];
    end
  end

  assign csr_wr       = idle_req && csr_hit && wbs_we_i;
  assign set_unmapped = idle_req && !csr_hit && !prj_hit;

  // Selected project's ack and data during BUSY
  always_comb begin
    ack_p = 1'b0;
    dat_p = '0;
    gate  = '0;
    for (int i = 0; i < NUM_PROJ; i++) begin
      if (prj_p1 == 4'(i)) begin
        ack_p   = prj_ack_i[i];
        dat_p   = prj_dat_i[32*i +: 32];
        gate[i] = (state == ST_BUSY);
      end
    end
  end

  assign to_next     = to_cnt + 16'd1;
  assign to_hit      = (to_next == TO_LIMIT);
  assign set_timeout = (state == ST_BUSY) && wbs_cyc_i && !ack_p && to_hit;

  wb_proj_mux_csr #(
    .NUM_PROJ (NUM_PROJ),
    .ID_WORD  (ID_WORD)
  ) u_csr (
    .clk          (wb_clk_i),
    .rst          (wb_rst_i),
    .wr_en        (csr_wr),
    .off          (wbs_adr_i[19:0]),
    .wdat         (wbs_dat_i),
    .sel          (wbs_sel_i),
    .set_timeout  (set_timeout),
    .timeout_slot (prj_p1 + 4'd1),
    .set_unmapped (set_unmapped),
    .proj_en      (proj_en),
    .proj_rst     (proj_rst),
    .rdata        (csr_rdata),
    .err_irq      (err_irq_o)
  );

  // Stage p1: request fields captured at strobe, held for the project
  always_ff @(posedge wb_clk_i) begin
    if (idle_req) begin
      we_p1  <= wbs_we_i;
      sel_p1 <= wbs_sel_i;
      adr_p1 <= wbs_adr_i[19:0];
      dat_p1 <= wbs_dat_i;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      to_cnt    <= 16'd0;
      prj_p1    <= 4'd0;
      wbs_dat_o <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (stb_req) begin
            if (csr_hit) begin
              wbs_dat_o <= csr_rdata;
              state     <= ST_RESP;
            end else if (prj_hit && slot_en) begin
              prj_p1 <= slot_prj;
              to_cnt <= 16'd0;
              state  <= ST_BUSY;
            end else begin
              wbs_dat_o <= ERR_WORD;
              state     <= ST_RESP;
            end
          end
        end
        ST_BUSY: begin
          // Master abort beats everything; ack beats a same-cycle timeout.
          if (!wbs_cyc_i) begin
            to_cnt <= 16'd0;
            state  <= ST_IDLE;
          end else if (ack_p) begin
            wbs_dat_o <= dat_p;
            to_cnt    <= 16'd0;
            state     <= ST_RESP;
          end else if (to_hit) begin
            wbs_dat_o <= ERR_WORD;
            to_cnt    <= 16'd0;
            state     <= ST_RESP;
          end else begin
            to_cnt <= to_next;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stage out: response and project-side drive
  assign wbs_ack_o = (state == ST_RESP);
  assign prj_cyc_o = gate;
  assign prj_stb_o = gate;
  assign prj_we_o  = we_p1;
  assign prj_sel_o = sel_p1;
  assign prj_adr_o = adr_p1;
  assign prj_dat_o = dat_p1;
  assign prj_rst_o = proj_rst | {NUM_PROJ{wb_rst_i}};

endmodule

// File: tb/tb_wb_proj_mux.sv
module tb_wb_proj_mux;

  localparam int          NP   = 4;
  localparam logic [31:0] ERRW = 32'hDEAD_BEEF;
  localparam logic [31:0] IDW  = 32'h1C5C_0001;
`ifdef WB_PROJ_MUX_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic             wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]       wbs_sel_i;
  logic [31:0]      wbs_adr_i, wbs_dat_i;
  logic             wbs_ack_o;
  logic [31:0]      wbs_dat_o;
  logic [NP-1:0]    prj_cyc_o, prj_stb_o;
  logic             prj_we_o;
  logic [3:0]       prj_sel_o;
  logic [19:0]      prj_adr_o;
  logic [31:0]      prj_dat_o;
  logic [NP-1:0]    prj_ack_i;
  logic [32*NP-1:0] prj_dat_i;
  logic [NP-1:0]    prj_rst_o;
  logic             err_irq_o;

  wb_proj_mux dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .prj_cyc_o (prj_cyc_o),
    .prj_stb_o (prj_stb_o),
    .prj_we_o  (prj_we_o),
    .prj_sel_o (prj_sel_o),
    .prj_adr_o (prj_adr_o),
    .prj_dat_o (prj_dat_o),
    .prj_ack_i (prj_ack_i),
    .prj_dat_i (prj_dat_i),
    .prj_rst_o (prj_rst_o),
    .err_irq_o (err_irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        chk;
    logic [31:0] dat;
    string       name;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        chk;
    logic [31:0] exp;
    int          lat;
    logic [3:0]  stb;
    string       name;
  } vec_t;
  vec_t vecs[20];

  // Project responder model: ack after dly[p] strobe cycles, dly 0 = never
  int          dly[NP];
  int          bcnt[NP];
  logic [31:0] pdat[NP];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    prj_ack_i = '0;
    prj_dat_i = '0;
    for (int p = 0; p < NP; p++) begin
      dly[p] = 0; bcnt[p] = 0; pdat[p] = 32'h0;
    end
    forever begin
      @(negedge wb_clk_i);
      for (int p = 0; p < NP; p++) begin
        prj_dat_i[32*p +: 32] = pdat[p];
        if (prj_stb_o[p]) begin
          bcnt[p]++;
          prj_ack_i[p] = (bcnt[p] == dly[p]);
        end else begin
          bcnt[p] = 0;
          prj_ack_i[p] = 1'b0;
        end
      end
    end
  end

  // Scoreboard consumer: every ack pops one expected response
  initial begin
    sb_t e;
    forever begin
      @(negedge wb_clk_i);
      if (!wb_rst_i && wbs_ack_o) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          if (e.chk) check(e.name, wbs_dat_o, e.dat);
        end
      end
    end
  end

  task automatic xfer(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                      input logic [3:0] sel, input logic chk, input logic [31:0] exp,
                      input int exp_lat, input logic [3:0] exp_stb, input string name);
    int          lat;
    logic        got;
    logic [3:0]  stb_seen;
    logic [3:0]  cyc_seen;
    logic [19:0] adr_seen;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = wdat; wbs_sel_i = sel;
    sb_q.push_back('{chk, exp, name});
    lat = 0; got = 1'b0; stb_seen = '0; cyc_seen = '0; adr_seen = '0;
    while (!got && lat < 1000) begin
      @(negedge wb_clk_i);
      lat++;
      stb_seen |= prj_stb_o;
      cyc_seen |= prj_cyc_o;
      if (prj_stb_o != '0) adr_seen = prj_adr_o;
      if (wbs_ack_o) got = 1'b1;
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    if (!got) begin
      void'(sb_q.pop_back());
      $display("FAIL %s_ack_timeout: got no ack expected ack", name);
      n_cmp++; n_err++;
    end else begin
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
    end
    check({name, "_stb"}, 32'(stb_seen), 32'(exp_stb));
    check({name, "_cyc"}, 32'(cyc_seen), 32'(exp_stb));
    if (exp_stb != '0) check({name, "_adr"}, 32'(adr_seen), 32'(adr[19:0]));
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp, input string name);
    xfer(adr, 1'b0, 32'h0, 4'hF, 1'b1, exp, 1, 4'b0000, name);
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] wdat, input logic [3:0] sel,
                    input string name);
    xfer(adr, 1'b1, wdat, sel, 1'b0, 32'h0, 1, 4'b0000, name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst_i = 1'b1;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = '0; wbs_dat_i = '0;

    vecs[0]  = '{32'h3000_000C, 1'b0, 32'h0,         4'hF, 1'b1, IDW,           1, 4'b0000, "id_rd"};
    vecs[1]  = '{32'h3000_0004, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_000F, 1, 4'b0000, "prst_reset"};
    vecs[2]  = '{32'h3000_0000, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0,         1, 4'b0000, "pen_reset"};
    vecs[3]  = '{32'h3000_0000, 1'b1, 32'hFFFF_FF02, 4'h1, 1'b0, 32'h0,         1, 4'b0000, "pen_wr"};
    vecs[4]  = '{32'h3000_0000, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0002, 1, 4'b0000, "pen_rd"};
    vecs[5]  = '{32'h3000_0004, 1'b1, 32'h0,         4'h2, 1'b0, 32'h0,         1, 4'b0000, "prst_wr_sel1"};
    vecs[6]  = '{32'h3000_0004, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_000F, 1, 4'b0000, "prst_keep"};
    vecs[7]  = '{32'h3000_0004, 1'b1, 32'hFFFF_FF05, 4'h1, 1'b0, 32'h0,         1, 4'b0000, "prst_wr"};
    vecs[8]  = '{32'h3000_0004, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0005, 1, 4'b0000, "prst_rd"};
    vecs[9]  = '{32'h3000_0010, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0,         1, 4'b0000, "undef_off"};
    vecs[10] = '{32'h3020_0010, 1'b0, 32'h0,         4'hF, 1'b1, 32'h1234_5678, 4, 4'b0010, "prj1_rd"};
    vecs[11] = '{32'h3030_0000, 1'b0, 32'h0,         4'hF, 1'b1, ERRW,          1, 4'b0000, "prj2_dis"};
    vecs[12] = '{32'h3050_0000, 1'b0, 32'h0,         4'hF, 1'b1, ERRW,          1, 4'b0000, "slot5_unmap"};
    vecs[13] = '{32'h3000_0008, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0100, 1, 4'b0000, "sts_unmap"};
    vecs[14] = '{32'h3000_0008, 1'b1, 32'h0000_0100, 4'h1, 1'b0, 32'h0,         1, 4'b0000, "sts_w1c_nosel"};
    vecs[15] = '{32'h3000_0008, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0000_0100, 1, 4'b0000, "sts_kept"};
    vecs[16] = '{32'h3000_0008, 1'b1, 32'h0000_0100, 4'h2, 1'b0, 32'h0,         1, 4'b0000, "sts_w1c"};
    vecs[17] = '{32'h3000_0008, 1'b0, 32'h0,         4'hF, 1'b1, 32'h0,         1, 4'b0000, "sts_clr"};
    vecs[18] = '{32'h3020_0040, 1'b1, 32'hCAFE_0001, 4'hF, 1'b0, 32'h0,         4, 4'b0010, "prj1_wr"};
    vecs[19] = '{32'h3000_000C, 1'b1, 32'h0,         4'hF, 1'b0, 32'h0,         1, 4'b0000, "id_wr"};

    repeat (3) @(negedge wb_clk_i);
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_stb", 32'(prj_stb_o), 32'd0);
    check("rst_prst", 32'(prj_rst_o), 32'hF);
    check("rst_irq", 32'(err_irq_o), 32'd0);
    wb_rst_i = 1'b0;

    dly[1] = 3; pdat[1] = 32'h1234_5678;
    for (int i = 0; i < 20; i++) begin
      xfer(vecs[i].adr, vecs[i].we, vecs[i].wdat, vecs[i].sel, vecs[i].chk,
           vecs[i].exp, vecs[i].lat, vecs[i].stb, vecs[i].name);
    end
    check("prj_rst_sw", 32'(prj_rst_o), 32'h5);
    rd(32'h3000_000C, IDW, "id_after_wr");

    // Timeout on project 0
    wr(32'h3000_0000, 32'h3, 4'h1, "pen_en01");
    dly[0] = 0;
    xfer(32'h3010_0000, 1'b0, 32'h0, 4'hF, 1'b1, ERRW, 256, 4'b0001, "prj0_timeout");
    rd(32'h3000_0008, 32'h0000_0011, "sts_timeout");
    check("irq_timeout", 32'(err_irq_o), 32'(IRQ_ON));
    wr(32'h3000_0008, 32'h1, 4'h1, "sts_clr_to");
    rd(32'h3000_0008, 32'h0000_0010, "sts_slot_kept");
    check("irq_clr", 32'(err_irq_o), 32'd0);

    // Region miss
    rd(32'h4000_0000, ERRW, "region_miss");
    rd(32'h3000_0008, 32'h0000_0110, "sts_miss");
    check("irq_miss", 32'(err_irq_o), 32'(IRQ_ON));
    wr(32'h3000_0008, 32'h100, 4'h2, "sts_clr_miss");
    check("irq_clr2", 32'(err_irq_o), 32'd0);

    // Ack on the timeout cycle: ack wins
    dly[0] = 255; pdat[0] = 32'hA5A5_0F0F;
    xfer(32'h3010_0004, 1'b0, 32'h0, 4'hF, 1'b1, 32'hA5A5_0F0F, 256, 4'b0001, "ack_vs_to");
    rd(32'h3000_0008, 32'h0000_0010, "sts_no_to");

    // Abort mid-BUSY
    dly[0] = 0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3010_0000; wbs_sel_i = 4'hF;
    repeat (4) @(negedge wb_clk_i);
    check("abort_busy_stb", 32'(prj_stb_o), 32'h1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    check("abort_idle_stb", 32'(prj_stb_o), 32'h0);
    check("abort_no_ack", 32'(wbs_ack_o), 32'd0);
    repeat (3) @(negedge wb_clk_i);
    rd(32'h3000_0008, 32'h0000_0010, "sts_abort");
    xfer(32'h3020_0000, 1'b0, 32'h0, 4'hF, 1'b1, 32'h1234_5678, 4, 4'b0010, "after_abort");

    // Reset during BUSY
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0;
    wbs_adr_i = 32'h3010_0000; wbs_sel_i = 4'hF;
    repeat (3) @(negedge wb_clk_i);
    #2 wb_rst_i = 1'b1;
    #1;
    check("rstbusy_stb", 32'(prj_stb_o), 32'h0);
    check("rstbusy_prst", 32'(prj_rst_o), 32'hF);
    check("rstbusy_ack", 32'(wbs_ack_o), 32'd0);
    check("rstbusy_dat", wbs_dat_o, 32'h0);
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    rd(32'h3000_0000, 32'h0, "pen_after_rst");
    rd(32'h3000_0004, 32'hF, "prst_after_rst");
    rd(32'h3000_0008, 32'h0, "sts_after_rst");
    check("prj_rst_after", 32'(prj_rst_o), 32'hF);

    repeat (2) @(negedge wb_clk_i);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
